// File: rtl/id_stage.sv
// rtl/id_stage.sv - MIPS decode stage: register file, control decode, branch/jump resolve, ID/EX register
module id_stage #(
  parameter int REGS  = 32,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      InstrD,
  input  logic [WIDTH-1:0] PCPlus4D,
  input  logic             RegWriteW,
  input  logic [4:0]       WriteRegW,
  input  logic [WIDTH-1:0] ResultW,
  input  logic [WIDTH-1:0] ALUOutM,
  input  logic             ForwardAD,
  input  logic             ForwardBD,
  input  logic             FlushE,
  output logic [WIDTH-1:0] PCBranchD,
  output logic             PCSrcD,
  output logic [4:0]       RsD,
  output logic [4:0]       RtD,
  output logic             RegWriteE,
  output logic             MemtoRegE,
  output logic             MemWriteE,
  output logic             ALUSrcE,
  output logic             RegDstE,
  output logic [2:0]       ALUControlE,
  output logic [WIDTH-1:0] RD1E,
  output logic [WIDTH-1:0] RD2E,
  output logic [WIDTH-1:0] SignImmE,
  output logic [4:0]       RsE,
  output logic [4:0]       RtE,
  output logic [4:0]       RdE
);

  typedef struct packed {
    logic             reg_write;
    logic             mem_to_reg;
    logic             mem_write;
    logic             alu_src;
    logic             reg_dst;
    logic [2:0]       alu_ctrl;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic [WIDTH-1:0] sign_imm;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [4:0]       rd;
  } idex_t;

  logic [WIDTH-1:0] rf_q [REGS];
  idex_t            idex_q, idex_d;

  logic [5:0]       opcode, funct;
  logic             reg_write, mem_to_reg, mem_write, alu_src, reg_dst, branch, jump;
  logic [2:0]       alu_ctrl;
  logic [WIDTH-1:0] rd1, rd2, sign_imm, cmp_a, cmp_b;
  logic             equal_d;

  assign opcode   = InstrD[31:26];
  assign funct    = InstrD[5:0];
  assign RsD      = InstrD[25:21];
  assign RtD      = InstrD[20:16];
  assign sign_imm = {{(WIDTH-16){InstrD[15]}}, InstrD[15:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REGS; i++) rf_q[i] <= '0;
    end else if (RegWriteW && (WriteRegW != 5'd0)) begin
      rf_q[WriteRegW] <= ResultW;
    end
  end

  // Write-through lets a same-cycle write-back feed both the compare and RD1E/RD2E
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (RsD != 5'd0) rd1 = (RegWriteW && (WriteRegW == RsD)) ? ResultW : rf_q[RsD];
    if (RtD != 5'd0) rd2 = (RegWriteW && (WriteRegW == RtD)) ? ResultW : rf_q[RtD];
  end

  always_comb begin
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    mem_write  = 1'b0;
    alu_src    = 1'b0;
    reg_dst    = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    alu_ctrl   = 3'b000;
    case (opcode)
      6'b000000: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        case (funct)
          6'b100000: alu_ctrl = 3'b010;
          6'b100010: alu_ctrl = 3'b110;
          6'b100100: alu_ctrl = 3'b000;
          6'b100101: alu_ctrl = 3'b001;
          6'b101010: alu_ctrl = 3'b111;
          default: begin
            reg_write = 1'b0;
            reg_dst   = 1'b0;
          end
        endcase
      end
      6'b100011: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        alu_src    = 1'b1;
        alu_ctrl   = 3'b010;
      end
      6'b101011: begin
        mem_write = 1'b1;
        alu_src   = 1'b1;
        alu_ctrl  = 3'b010;
      end
      6'b001000: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        alu_ctrl  = 3'b010;
      end
      6'b000100: begin
        branch   = 1'b1;
        alu_ctrl = 3'b110;
      end
      6'b000010: jump = 1'b1;
      default: ;
    endcase
  end

  assign cmp_a   = ForwardAD ? ALUOutM : rd1;
  assign cmp_b   = ForwardBD ? ALUOutM : rd2;
  assign equal_d = (cmp_a == cmp_b);
  assign PCSrcD  = (branch & equal_d) | jump;
  assign PCBranchD = jump ? {PCPlus4D[WIDTH-1:28], InstrD[25:0], 2'b00}
                          : PCPlus4D + {sign_imm[WIDTH-3:0], 2'b00};

  always_comb begin
    idex_d = '0;
    if (!FlushE) begin
      idex_d.reg_write  = reg_write;
      idex_d.mem_to_reg = mem_to_reg;
      idex_d.mem_write  = mem_write;
      idex_d.alu_src    = alu_src;
      idex_d.reg_dst    = reg_dst;
      idex_d.alu_ctrl   = alu_ctrl;
      idex_d.rd1        = rd1;
      idex_d.rd2        = rd2;
      idex_d.sign_imm   = sign_imm;
      idex_d.rs         = RsD;
      idex_d.rt         = RtD;
      idex_d.rd         = InstrD[15:11];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idex_q <= '0;
    else        idex_q <= idex_d;
  end

  assign RegWriteE   = idex_q.reg_write;
  assign MemtoRegE   = idex_q.mem_to_reg;
  assign MemWriteE   = idex_q.mem_write;
  assign ALUSrcE     = idex_q.alu_src;
  assign RegDstE     = idex_q.reg_dst;
  assign ALUControlE = idex_q.alu_ctrl;
  assign RD1E        = idex_q.rd1;
  assign RD2E        = idex_q.rd2;
  assign SignImmE    = idex_q.sign_imm;
  assign RsE         = idex_q.rs;
  assign RtE         = idex_q.rt;
  assign RdE         = idex_q.rd;

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - scoreboard bench for id_stage against a behavioural decode model
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] InstrD, PCPlus4D, ResultW, ALUOutM;
  logic        RegWriteW, ForwardAD, ForwardBD, FlushE;
  logic [4:0]  WriteRegW;
  logic [31:0] PCBranchD;
  logic        PCSrcD;
  logic [4:0]  RsD, RtD;
  logic        RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, SignImmE;
  logic [4:0]  RsE, RtE, RdE;

  id_stage dut (
    .clk(clk), .rst_n(rst_n), .InstrD(InstrD), .PCPlus4D(PCPlus4D),
    .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW),
    .ALUOutM(ALUOutM), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .FlushE(FlushE),
    .PCBranchD(PCBranchD), .PCSrcD(PCSrcD), .RsD(RsD), .RtD(RtD),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .ALUSrcE(ALUSrcE), .RegDstE(RegDstE), .ALUControlE(ALUControlE),
    .RD1E(RD1E), .RD2E(RD2E), .SignImmE(SignImmE), .RsE(RsE), .RtE(RtE), .RdE(RdE)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rw, m2r, mw, asrc, rdst;
    logic [2:0]  op;
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rs, rt, rd;
  } e_t;

  typedef struct {
    e_t          e;
    logic        pcsrc;
    logic [31:0] pcbr;
    logic [4:0]  rs, rt;
    bit          gold;
    logic        gpcsrc;
    logic [31:0] gpcbr;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;

  logic [31:0] regs [32];
  e_t          pend, e_now;

  // stimulus staged for the next issue
  logic        s_rst, s_rw, s_fa, s_fb, s_fl;
  logic [4:0]  s_wr;
  logic [31:0] s_instr, s_pc, s_res, s_alu;
  bit          s_gold;
  logic        s_gpcsrc;
  logic [31:0] s_gpcbr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rd_model(input logic [4:0] idx);
    if (idx == 0) return 32'd0;
    if (RegWriteW && WriteRegW == idx) return ResultW;
    return regs[idx];
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      chk("PCSrcD", {31'd0, PCSrcD}, {31'd0, x.pcsrc});
      chk("PCBranchD", PCBranchD, x.pcbr);
      chk("RsD", {27'd0, RsD}, {27'd0, x.rs});
      chk("RtD", {27'd0, RtD}, {27'd0, x.rt});
      chk("E_ctrl", {27'd0, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE},
          {27'd0, x.e.rw, x.e.m2r, x.e.mw, x.e.asrc, x.e.rdst});
      chk("ALUControlE", {29'd0, ALUControlE}, {29'd0, x.e.op});
      chk("RD1E", RD1E, x.e.rd1);
      chk("RD2E", RD2E, x.e.rd2);
      chk("SignImmE", SignImmE, x.e.imm);
      chk("RsRtRdE", {17'd0, RsE, RtE, RdE}, {17'd0, x.e.rs, x.e.rt, x.e.rd});
      if (x.gold) begin
        chk("gold_PCSrcD", {31'd0, PCSrcD}, {31'd0, x.gpcsrc});
        if (x.gpcsrc) chk("gold_PCBranchD", PCBranchD, x.gpcbr);
      end
    end
  end

  task automatic issue();
    exp_t        x;
    logic [5:0]  opc, fn;
    logic        rw, m2r, mw, asrc, rdst, br, jmp;
    logic [2:0]  op;
    logic [31:0] a, b, imm;
    @(posedge clk);
    #1;
    // effect of the edge that just happened, using the inputs held through it
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] = 0;
      e_now = '0;
    end else begin
      if (RegWriteW && WriteRegW != 0) regs[WriteRegW] = ResultW;
      e_now = FlushE ? '0 : pend;
    end
    rst_n = s_rst; InstrD = s_instr; PCPlus4D = s_pc; RegWriteW = s_rw;
    WriteRegW = s_wr; ResultW = s_res; ALUOutM = s_alu;
    ForwardAD = s_fa; ForwardBD = s_fb; FlushE = s_fl;
    if (!s_rst) begin
      for (int i = 0; i < 32; i++) regs[i] = 0;
      e_now = '0;
    end
    opc = s_instr[31:26];
    fn  = s_instr[5:0];
    {rw, m2r, mw, asrc, rdst, br, jmp} = '0;
    op = 3'b000;
    if (opc == 6'h00 && fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a}) begin
      rw = 1; rdst = 1;
      op = (fn == 6'h20) ? 3'd2 : (fn == 6'h22) ? 3'd6 : (fn == 6'h24) ? 3'd0 :
           (fn == 6'h25) ? 3'd1 : 3'd7;
    end else if (opc == 6'h23) begin rw = 1; m2r = 1; asrc = 1; op = 3'd2; end
    else if (opc == 6'h2b) begin mw = 1; asrc = 1; op = 3'd2; end
    else if (opc == 6'h08) begin rw = 1; asrc = 1; op = 3'd2; end
    else if (opc == 6'h04) begin br = 1; op = 3'd6; end
    else if (opc == 6'h02) jmp = 1;
    imm = 32'(signed'(s_instr[15:0]));
    a = s_fa ? s_alu : rd_model(s_instr[25:21]);
    b = s_fb ? s_alu : rd_model(s_instr[20:16]);
    x.pcsrc = (br && a == b) || jmp;
    x.pcbr  = jmp ? {s_pc[31:28], s_instr[25:0], 2'b00} : s_pc + imm * 4;
    x.rs = s_instr[25:21];
    x.rt = s_instr[20:16];
    x.e  = e_now;
    x.gold = s_gold; x.gpcsrc = s_gpcsrc; x.gpcbr = s_gpcbr;
    pend = '{rw, m2r, mw, asrc, rdst, op, rd_model(s_instr[25:21]), rd_model(s_instr[20:16]),
             imm, s_instr[25:21], s_instr[20:16], s_instr[15:11]};
    sb.push_back(x);
    s_gold = 0;
  endtask

  task automatic stim(input logic [31:0] instr, input logic [31:0] pc, input logic rw,
                      input logic [4:0] wr, input logic [31:0] res, input logic fa,
                      input logic [31:0] alu, input logic fl);
    s_instr = instr; s_pc = pc; s_rw = rw; s_wr = wr; s_res = res;
    s_fa = fa; s_fb = 0; s_alu = alu; s_fl = fl;
    issue();
  endtask

  task automatic gold(input logic pcsrc, input logic [31:0] pcbr);
    s_gold = 1; s_gpcsrc = pcsrc; s_gpcbr = pcbr;
  endtask

  task automatic random_step();
    logic [5:0] opcs [7];
    logic [5:0] fns  [6];
    logic [5:0] opc, fn;
    opcs = '{6'h00, 6'h23, 6'h2b, 6'h08, 6'h04, 6'h02, 6'h00};
    fns  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00};
    opc = opcs[$urandom_range(0, 6)];
    if ($urandom_range(0, 9) == 0) opc = 6'($urandom);
    fn = fns[$urandom_range(0, 5)];
    if ($urandom_range(0, 9) == 0) fn = 6'($urandom);
    s_instr = {opc, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom), 5'($urandom), fn};
    if ($urandom_range(0, 1) == 0) s_instr[15:0] = 16'($urandom);
    s_pc  = $urandom & 32'hFFFF_FFFC;
    s_rw  = 1'($urandom);
    s_wr  = 5'($urandom_range(0, 7));
    s_res = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
    s_fa  = ($urandom_range(0, 3) == 0);
    s_fb  = ($urandom_range(0, 3) == 0);
    s_alu = ($urandom_range(0, 1) == 0) ? regs[s_instr[20:16]] : $urandom;
    s_fl  = ($urandom_range(0, 7) == 0);
    issue();
  endtask

  initial begin
    rst_n = 0; InstrD = 0; PCPlus4D = 0; RegWriteW = 0; WriteRegW = 0; ResultW = 0;
    ALUOutM = 0; ForwardAD = 0; ForwardBD = 0; FlushE = 0;
    for (int i = 0; i < 32; i++) regs[i] = 0;
    pend = '0; e_now = '0; s_gold = 0; s_fb = 0;
    s_rst = 0;
    stim(32'h0, 32'h0, 0, 0, 0, 0, 0, 0);
    s_rst = 1;
    // write-through: reg8 written while beq $8,$0 compares
    gold(0, 32'h0);
    stim(32'h1100_0003, 32'h40, 1, 8, 32'h5, 0, 0, 0);
    gold(1, 32'h3C);
    stim(32'h1108_FFFF, 32'h40, 0, 0, 0, 0, 0, 0);
    gold(1, 32'h1000_0040);
    stim(32'h0800_0010, 32'h1000_0004, 0, 0, 0, 0, 0, 0);
    stim(32'h0, 32'h0, 1, 9, 32'h7, 0, 0, 0);
    stim(32'h0, 32'h0, 1, 10, 32'h3, 0, 0, 0);
    gold(1, 32'h28);
    stim(32'h112A_0002, 32'h20, 0, 0, 0, 1, 32'h3, 0);
    gold(0, 32'h0);
    stim(32'h112A_0002, 32'h20, 0, 0, 0, 0, 32'h3, 0);
    stim(32'h8C62_FFFC, 32'h100, 0, 0, 0, 0, 0, 0);
    stim(32'h00A6_2020, 32'h104, 1, 0, 32'hFFFF_FFFF, 0, 0, 1);
    stim(32'h0000_0820, 32'h108, 0, 0, 0, 0, 0, 0);
    gold(1, 32'h10C);
    stim(32'h1000_0000, 32'h10C, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 150; i++) random_step();
    // asynchronous reset mid-run with registers loaded, held across one edge
    s_rst = 0;
    random_step();
    random_step();
    s_rst = 1;
    stim(32'h0109_0020, 32'h200, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 150; i++) random_step();
    stim(32'h0, 32'h0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode stage of the 5-stage MIPS pipeline.
- Consumes InstrD/PCPlus4D from the fetch stage; returns PCBranchD/PCSrcD to it.
- Holds the 32x32 register file; resolves beq/j in decode with M-stage forwarding.
- Drives the ID/EX pipeline register toward execute.

Parameters:
- REGS, 32, number of architectural registers (index width 5).
- WIDTH, 32, datapath width.

Ports:
- clk  in  1  pipeline clock, rising-edge active.
- rst_n  in  1  asynchronous, active-low reset.
- InstrD  in  32  instruction in decode.
- PCPlus4D  in  32  PC+4 of InstrD.
- RegWriteW  in  1  write-back enable.
- WriteRegW  in  5  write-back register index.
- ResultW  in  32  write-back data.
- ALUOutM  in  32  M-stage ALU result for branch forwarding.
- ForwardAD  in  1  use ALUOutM for the rs compare operand.
- ForwardBD  in  1  use ALUOutM for the rt compare operand.
- FlushE  in  1  load a bubble into ID/EX.
- PCBranchD  out  32  redirect target to fetch.
- PCSrcD  out  1  take redirect.
- RsD, RtD  out  5 each  source indices for the hazard unit.
- RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE  out  1 each  registered controls.
- ALUControlE  out  3  registered ALU op.
- RD1E, RD2E, SignImmE  out  32 each  registered operands and immediate.
- RsE, RtE, RdE  out  5 each  registered register indices.

Behaviour:
- Reset (rst_n=0): asynchronously clears all 32 registers and every E-stage output to 0. It takes effect immediately, including mid-operation. Operation resumes on the first rising edge after rst_n=1.
- Register file write: on rising edge when RegWriteW=1 and WriteRegW!=0, reg[WriteRegW]<=ResultW. reg[0] always reads 0.
- Register file read: combinational, with write-through. If RegWriteW=1, WriteRegW!=0 and it equals the read index, the read returns ResultW in the same cycle.
- Decode (combinational, from InstrD[31:26]; funct = InstrD[5:0]):
  - R-type 000000: RegWrite=1, RegDst=1. funct add 100000->010, sub 100010->110, and 100100->000, or 100101->001, slt 101010->111. Any other funct: all controls 0.
  - lw 100011: RegWrite, MemtoReg, ALUSrc; op 010.
  - sw 101011: MemWrite, ALUSrc; op 010.
  - addi 001000: RegWrite, ALUSrc; op 010.
  - beq 000100: Branch; op 110.
  - j 000010: Jump.
  - Any other opcode: all controls 0 (nop).
- SignImm = sign-extended InstrD[15:0].
- Branch compare:
  - A = ForwardAD ? ALUOutM : RD1; B = ForwardBD ? ALUOutM : RD2; EqualD = (A==B).
- Redirect (combinational, zero latency):
  - PCSrcD = (Branch & EqualD) | Jump.
  - PCBranchD = Jump ? {PCPlus4D[31:28], InstrD[25:0], 2'b00} : PCPlus4D + (SignImm<<2). Add is modulo 2^32; wrap is allowed.
  - When PCSrcD=0, PCBranchD is don't-care but deterministic.
- RsD = InstrD[25:21]; RtD = InstrD[20:16].
- ID/EX register (rising edge):
  - FlushE=1: all E outputs <= 0 (bubble); FlushE wins over new data.
  - Otherwise: latch the decoded controls, RD1, RD2 (unforwarded register-file values with write-through), SignImm, Rs, Rt, Rd = InstrD[15:11].
  - Reset overrides FlushE.
- Simultaneous write-back to rs and read of rs in the same cycle: new value is used for both the compare and RD1E.

Test Plan:
- Reset: assert rst_n=0 mid-run with registers loaded -> all E outputs 0 immediately; after release, reading any register returns 0.
- Write-through: RegWriteW=1, WriteRegW=8, ResultW=0x0000_0005, InstrD=beq $8,$0,+3, PCPlus4D=0x40. Required response: EqualD=0, PCSrcD=0. Next cycle reg8=5; beq $8,$8,-1 at PCPlus4D=0x40 -> PCSrcD=1, PCBranchD=0x3C.
- Jump: InstrD=0x0800_0010, PCPlus4D=0x1000_0004 -> PCSrcD=1, PCBranchD=0x1000_0040; next edge RegWriteE=MemWriteE=0.
- Forwarding: reg9=7, ALUOutM=3, reg10=3, ForwardAD=1, beq $9,$10,+2 at PCPlus4D=0x20 -> PCSrcD=1, PCBranchD=0x28. With ForwardAD=0 -> PCSrcD=0.
- Decode/register: InstrD=lw $2,-4($3) (0x8C62_FFFC) -> next edge RegWriteE=1, MemtoRegE=1, ALUSrcE=1, ALUControlE=010, SignImmE=0xFFFF_FFFC, RsE=3, RtE=2.
- Flush and write to $0: InstrD=add $4,$5,$6 with FlushE=1 -> next edge all E outputs 0. RegWriteW=1, WriteRegW=0, ResultW=0xFFFF_FFFF -> $0 still reads 0.
